// File: rtl/debug_monitor.sv
// Clocked debug display front end: picks a CPU register or the PC, captures it and
// presents one page of hex digits. Optional zero-register skipping in auto-scan: DBG_SKIP_ZERO_EN.
module debug_monitor #(
  parameter int WORD_W = 32,
  parameter int DIGITS = 4,
  parameter int ADRS_W = 5,
  parameter int DWELL  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [ADRS_W-1:0]     sw_adrs,
  input  logic [1:0]            page_sel,
  input  logic [WORD_W-1:0]     pc,
  input  logic [WORD_W-1:0]     reg_dbg_q,
  output logic [ADRS_W-1:0]     reg_dbg_adrs,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  digit_valid,
  output logic [ADRS_W-1:0]     cur_adrs
);

  localparam int PW      = 4 * DIGITS;
  localparam int NPAGES  = WORD_W / PW;
  localparam int NSEL    = (NPAGES < 4) ? NPAGES : 4;
  localparam int DWELL_W = $clog2(DWELL);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  localparam logic [1:0] MODE_REG    = 2'b00;
  localparam logic [1:0] MODE_PC     = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  typedef enum logic {SHOW, FETCH} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shown_q, shown_d;
  logic [ADRS_W-1:0]   reg_dbg_adrs_q, reg_dbg_adrs_d;
  logic [ADRS_W-1:0]   cur_adrs_q, cur_adrs_d;
  logic                digit_valid_q, digit_valid_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [1:0]          mode_prev_q;

  logic [DWELL_W-1:0]  dwell_eff;
  logic                sw_change;
  logic                dwell_expire;
  logic                skip_zero;

`ifdef DBG_SKIP_ZERO_EN
  localparam logic [ADRS_W-1:0] SKIP_MAX = {ADRS_W{1'b1}};
  logic [ADRS_W-1:0]   skip_cnt_q, skip_cnt_d;
`endif

  // A mode change seen this cycle restarts the dwell count from zero.
  always_comb begin
    dwell_eff    = (mode != mode_prev_q) ? '0 : dwell_cnt_q;
    sw_change    = (sw_adrs != reg_dbg_adrs_q);
    dwell_expire = (dwell_eff == DWELL_LAST);
`ifdef DBG_SKIP_ZERO_EN
    skip_zero    = (mode == MODE_SCAN) && (reg_dbg_q == '0) && (skip_cnt_q != SKIP_MAX);
`else
    skip_zero    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SHOW;
      shown_q        <= '0;
      reg_dbg_adrs_q <= '0;
      cur_adrs_q     <= '0;
      digit_valid_q  <= 1'b0;
      dwell_cnt_q    <= '0;
      mode_prev_q    <= MODE_REG;
`ifdef DBG_SKIP_ZERO_EN
      skip_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      shown_q        <= shown_d;
      reg_dbg_adrs_q <= reg_dbg_adrs_d;
      cur_adrs_q     <= cur_adrs_d;
      digit_valid_q  <= digit_valid_d;
      dwell_cnt_q    <= dwell_cnt_d;
      mode_prev_q    <= mode;
`ifdef DBG_SKIP_ZERO_EN
      skip_cnt_q     <= skip_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW: begin
        if (mode == MODE_REG && sw_change)
          state_d = FETCH;
        else if (mode == MODE_SCAN && dwell_expire)
          state_d = FETCH;
      end
      FETCH: begin
        if (!skip_zero)
          state_d = SHOW;
      end
      default: state_d = SHOW;
    endcase
  end

  always_comb begin
    shown_d        = shown_q;
    reg_dbg_adrs_d = reg_dbg_adrs_q;
    cur_adrs_d     = cur_adrs_q;
    digit_valid_d  = digit_valid_q;
    dwell_cnt_d    = dwell_eff;
`ifdef DBG_SKIP_ZERO_EN
    skip_cnt_d     = skip_cnt_q;
`endif
    case (state_q)
      SHOW: begin
        case (mode)
          MODE_REG: begin
            dwell_cnt_d = '0;
            if (sw_change) begin
              reg_dbg_adrs_d = sw_adrs;
              digit_valid_d  = 1'b0;
            end else begin
              shown_d       = reg_dbg_q;
              cur_adrs_d    = reg_dbg_adrs_q;
              digit_valid_d = 1'b1;
            end
          end
          MODE_PC: begin
            dwell_cnt_d   = '0;
            shown_d       = pc;
            digit_valid_d = 1'b1;
          end
          MODE_SCAN: begin
            if (dwell_expire) begin
              dwell_cnt_d    = '0;
              reg_dbg_adrs_d = reg_dbg_adrs_q + ADRS_W'(1);
              digit_valid_d  = 1'b0;
            end else begin
              dwell_cnt_d   = dwell_eff + DWELL_W'(1);
              shown_d       = reg_dbg_q;
              cur_adrs_d    = reg_dbg_adrs_q;
              digit_valid_d = 1'b1;
            end
          end
          MODE_FREEZE: ;
          default: ;
        endcase
      end
      FETCH: begin
        if (skip_zero) begin
          reg_dbg_adrs_d = reg_dbg_adrs_q + ADRS_W'(1);
`ifdef DBG_SKIP_ZERO_EN
          skip_cnt_d     = skip_cnt_q + ADRS_W'(1);
`endif
        end else begin
          shown_d       = reg_dbg_q;
          cur_adrs_d    = reg_dbg_adrs_q;
          digit_valid_d = 1'b1;
`ifdef DBG_SKIP_ZERO_EN
          skip_cnt_d    = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Out-of-range pages fall back to page 0.
  always_comb begin
    digits = shown_q[PW-1:0];
    for (int p = 1; p < NSEL; p++)
      if (page_sel == 2'(p))
        digits = shown_q[p*PW +: PW];
  end

  assign reg_dbg_adrs = reg_dbg_adrs_q;
  assign cur_adrs     = cur_adrs_q;
  assign digit_valid  = digit_valid_q;

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor (DWELL=4): vector table for manual/PC/freeze/paging,
// hand sequences for reset mid-fetch, auto-scan wrap and zero skipping.
module tb_debug_monitor;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [4:0]  sw_adrs;
  logic [1:0]  page_sel;
  logic [31:0] pc;
  logic [31:0] reg_dbg_q;
  logic [4:0]  reg_dbg_adrs;
  logic [15:0] digits;
  logic        digit_valid;
  logic [4:0]  cur_adrs;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_fails  = 0;

  debug_monitor #(.WORD_W(32), .DIGITS(4), .ADRS_W(5), .DWELL(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .sw_adrs      (sw_adrs),
    .page_sel     (page_sel),
    .pc           (pc),
    .reg_dbg_q    (reg_dbg_q),
    .reg_dbg_adrs (reg_dbg_adrs),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .cur_adrs     (cur_adrs)
  );

  assign reg_dbg_q = regs[reg_dbg_adrs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sw;
    logic [1:0]  page;
    logic [31:0] pc;
    logic [15:0] exp_digits;
    logic        exp_valid;
    logic [4:0]  exp_adrs;
    logic [4:0]  exp_cur;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] d, input logic v,
                         input logic [4:0] a, input logic [4:0] c);
    chk({tag, " digits"}, 32'(digits), 32'(d));
    chk({tag, " valid"}, 32'(digit_valid), 32'(v));
    chk({tag, " adrs"}, 32'(reg_dbg_adrs), 32'(a));
    chk({tag, " cur"}, 32'(cur_adrs), 32'(c));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h0101_0101;
    regs[3] = 32'hDEAD_BEEF;
    regs[7] = 32'hCAFE_1234;

    //            mode   sw  page  pc            digits    v     adrs cur
    vecs[0]  = '{2'b00, 5'd3, 2'd0, 32'h0,        16'h0505, 1'b0, 5'd3, 5'd5};
    vecs[1]  = '{2'b00, 5'd3, 2'd0, 32'h0,        16'hBEEF, 1'b1, 5'd3, 5'd3};
    vecs[2]  = '{2'b00, 5'd3, 2'd1, 32'h0,        16'hDEAD, 1'b1, 5'd3, 5'd3};
    vecs[3]  = '{2'b00, 5'd3, 2'd2, 32'h0,        16'hBEEF, 1'b1, 5'd3, 5'd3};
    vecs[4]  = '{2'b00, 5'd3, 2'd3, 32'h0,        16'hBEEF, 1'b1, 5'd3, 5'd3};
    vecs[5]  = '{2'b01, 5'd3, 2'd0, 32'h100,      16'h0100, 1'b1, 5'd3, 5'd3};
    vecs[6]  = '{2'b01, 5'd3, 2'd0, 32'h104,      16'h0104, 1'b1, 5'd3, 5'd3};
    vecs[7]  = '{2'b11, 5'd3, 2'd0, 32'h108,      16'h0104, 1'b1, 5'd3, 5'd3};
    vecs[8]  = '{2'b11, 5'd3, 2'd0, 32'h10C,      16'h0104, 1'b1, 5'd3, 5'd3};
    vecs[9]  = '{2'b11, 5'd7, 2'd0, 32'h110,      16'h0104, 1'b1, 5'd3, 5'd3};
    vecs[10] = '{2'b00, 5'd7, 2'd0, 32'h110,      16'h0104, 1'b0, 5'd7, 5'd3};
    vecs[11] = '{2'b00, 5'd7, 2'd1, 32'h110,      16'hCAFE, 1'b1, 5'd7, 5'd7};
    vecs[12] = '{2'b01, 5'd7, 2'd1, 32'hABCD1234, 16'hABCD, 1'b1, 5'd7, 5'd7};

    reset = 1'b1; mode = 2'b00; sw_adrs = 5'd0; page_sel = 2'd0; pc = 32'h0;
    step();
    step();
    chk_all("reset", 16'h0, 1'b0, 5'd0, 5'd0);

    // Reset arriving while a fetch is in flight.
    reset = 1'b0;
    step();
    chk("post-reset refresh valid", 32'(digit_valid), 32'd1);
    sw_adrs = 5'd5;
    step();
    chk_all("fetch start", 16'h0, 1'b0, 5'd5, 5'd0);
    reset = 1'b1;
    step();
    chk_all("reset mid-fetch", 16'h0, 1'b0, 5'd0, 5'd0);
    reset = 1'b0;
    step();
    chk_all("re-fetch from SHOW", 16'h0, 1'b0, 5'd5, 5'd0);
    step();
    chk_all("capture reg5", 16'h0505, 1'b1, 5'd5, 5'd5);

    for (int i = 0; i < 13; i++) begin
      mode = vecs[i].mode; sw_adrs = vecs[i].sw; page_sel = vecs[i].page; pc = vecs[i].pc;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_valid,
              vecs[i].exp_adrs, vecs[i].exp_cur);
    end

    // Page select is combinational: no clock edge between change and check.
    page_sel = 2'd0;
    #1;
    chk("page comb 0", 32'(digits), 32'h1234);
    page_sel = 2'd1;
    #1;
    chk("page comb 1", 32'(digits), 32'hABCD);

    // Live refresh in manual mode picks up a changed register value.
    mode = 2'b00; page_sel = 2'd0; regs[7] = 32'h1111_2222;
    step();
    chk_all("live refresh", 16'h2222, 1'b1, 5'd7, 5'd7);

    // Auto-scan wrap from address 31.
    regs[0] = 32'h0000_ABCD;
    sw_adrs = 5'd31;
    step();
    step();
    chk_all("select 31", 16'h1F1F, 1'b1, 5'd31, 5'd31);
    mode = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all($sformatf("scan dwell%0d", k), 16'h1F1F, 1'b1, 5'd31, 5'd31);
    end
    step();
    chk_all("scan wrap", 16'h1F1F, 1'b0, 5'd0, 5'd31);
    step();
    chk_all("scan fetch 0", 16'hABCD, 1'b1, 5'd0, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all($sformatf("scan hold%0d", k), 16'hABCD, 1'b1, 5'd0, 5'd0);
    end
    step();
    chk_all("scan next", 16'hABCD, 1'b0, 5'd1, 5'd0);
    step();
    chk_all("scan fetch 1", 16'h0101, 1'b1, 5'd1, 5'd1);

`ifdef DBG_SKIP_ZERO_EN
    // Registers 1..4 zero: the search lands on register 5.
    for (int i = 1; i <= 4; i++) regs[i] = 32'h0;
    regs[5] = 32'h0000_0012;
    mode = 2'b00; sw_adrs = 5'd0;
    step();
    step();
    chk_all("skip setup", 16'hABCD, 1'b1, 5'd0, 5'd0);
    mode = 2'b10;
    for (int k = 0; k < 3; k++) step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("skip low%0d", k), 16'hABCD, 1'b0, 5'(k), 5'd0);
    end
    step();
    chk_all("skip land", 16'h0012, 1'b1, 5'd5, 5'd5);

    // Every register zero: the search gives up after 31 skips and shows 0.
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    mode = 2'b00; sw_adrs = 5'd0;
    step();
    step();
    chk_all("allzero setup", 16'h0, 1'b1, 5'd0, 5'd0);
    mode = 2'b10;
    for (int k = 0; k < 4; k++) step();
    chk_all("allzero expire", 16'h0, 1'b0, 5'd1, 5'd0);
    for (int k = 1; k <= 31; k++) begin
      step();
      chk($sformatf("allzero skip%0d valid", k), 32'(digit_valid), 32'd0);
    end
    step();
    chk_all("allzero latch", 16'h0, 1'b1, 5'd0, 5'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
